// File: rtl/ldpc_decoder_pkg.sv
// Shared defaults and unloader state encoding for the LDPC decoder hard-decision path.
package ldpc_decoder_pkg;

  localparam int HDWIDTH_DEFAULT      = 32;
  localparam int KB_DEFAULT           = 14;
  localparam int UNLOAD_DEPTH_DEFAULT = 16;
  localparam int ADDRESSWIDTH_DEFAULT = 5;
  localparam int RD_LATENCY_DEFAULT   = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } hdu_state_e;

endpackage

// File: rtl/ldpc_hd_beat_serializer.sv
// Holds captured Lmem words and slices them into HDWIDTH beats, column 0 first.
// With HDU_PREFETCH_EN defined, two ping-pong holding registers allow a load while draining.
module ldpc_hd_beat_serializer #(
  parameter int HDWIDTH = 32,
  parameter int Kb      = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    final_i,
  input  logic [Kb*HDWIDTH-1:0]   word_i,
  input  logic                    ready_i,
  output logic [HDWIDTH-1:0]      data_o,
  output logic                    valid_o,
  output logic                    last_o,
`ifdef HDU_PREFETCH_EN
  output logic                    can_load_o
`else
  output logic                    addr_done_o
`endif
);

  localparam int BW = (Kb > 1) ? $clog2(Kb) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(Kb - 1);

  logic [BW-1:0] beat_q;
  logic          accept;
  logic          buf_drained;

  assign accept      = valid_o & ready_i;
  assign buf_drained = accept & (beat_q == LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q <= '0;
    end else if (accept) begin
      beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end
  end

`ifdef HDU_PREFETCH_EN
  logic [Kb-1:0][HDWIDTH-1:0] hold_q [2];
  logic [1:0]                 full_q;
  logic [1:0]                 final_q;
  logic                       wr_sel_q;
  logic                       rd_sel_q;

  assign valid_o    = full_q[rd_sel_q];
  assign data_o     = hold_q[rd_sel_q][beat_q];
  assign last_o     = valid_o & final_q[rd_sel_q] & (beat_q == LAST_BEAT);
  assign can_load_o = ~full_q[wr_sel_q];

  // A load only targets a free buffer and a drain only clears a full one, so they never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q[0] <= '0;
      hold_q[1] <= '0;
      full_q    <= '0;
      final_q   <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
    end else begin
      if (load_i) begin
        hold_q[wr_sel_q]  <= word_i;
        full_q[wr_sel_q]  <= 1'b1;
        final_q[wr_sel_q] <= final_i;
        wr_sel_q          <= ~wr_sel_q;
      end
      if (buf_drained) begin
        full_q[rd_sel_q] <= 1'b0;
        rd_sel_q         <= ~rd_sel_q;
      end
    end
  end
`else
  logic [Kb-1:0][HDWIDTH-1:0] hold_q;
  logic                       full_q;
  logic                       final_q;

  assign valid_o     = full_q;
  assign data_o      = hold_q[beat_q];
  assign last_o      = full_q & final_q & (beat_q == LAST_BEAT);
  assign addr_done_o = buf_drained;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q  <= '0;
      full_q  <= 1'b0;
      final_q <= 1'b0;
    end else if (load_i) begin
      hold_q  <= word_i;
      full_q  <= 1'b1;
      final_q <= final_i;
    end else if (buf_drained) begin
      full_q <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/ldpc_hd_unloader.sv
// Unloads decoded hard decisions from Lmem and streams them as HDWIDTH beats.
// Optional macro HDU_PREFETCH_EN overlaps the next address read with the current send.
module ldpc_hd_unloader
  import ldpc_decoder_pkg::*;
#(
  parameter int HDWIDTH      = HDWIDTH_DEFAULT,
  parameter int Kb           = KB_DEFAULT,
  parameter int UNLOAD_DEPTH = UNLOAD_DEPTH_DEFAULT,
  parameter int ADDRESSWIDTH = ADDRESSWIDTH_DEFAULT,
  parameter int RD_LATENCY   = RD_LATENCY_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    decoder_ready,
  input  logic [Kb*HDWIDTH-1:0]   unload_HDout_vec_regout,
  output logic                    unload_en,
  output logic [ADDRESSWIDTH-1:0] unloadAddress,
  // Stream: a beat moves on a rising edge where m_valid & m_ready; while m_valid is high
  // and m_ready low, m_data/m_last hold their values and m_valid stays high.
  output logic [HDWIDTH-1:0]      m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done,
  output hdu_state_e              dbg_state
);

  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LW-1:0]           LAT_END   = LW'(RD_LATENCY - 1);
  localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(UNLOAD_DEPTH - 1);

  hdu_state_e              state_q, state_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]           lat_q, lat_d;
  logic                    dr_q;
  logic                    armed_q;
  logic                    start;
  logic                    load;
  logic                    final_addr;
`ifdef HDU_PREFETCH_EN
  logic                    rd_done_q, rd_done_d;
  logic                    can_load;
`else
  logic                    addr_done;
`endif

  // armed_q demands a low level after reset, so a level already high at release is not a start.
  assign start      = decoder_ready & ~dr_q & armed_q;
  assign final_addr = (addr_q == LAST_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      lat_q     <= '0;
      dr_q      <= 1'b0;
      armed_q   <= 1'b0;
`ifdef HDU_PREFETCH_EN
      rd_done_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lat_q     <= lat_d;
      dr_q      <= decoder_ready;
      armed_q   <= armed_q | ~decoder_ready;
`ifdef HDU_PREFETCH_EN
      rd_done_q <= rd_done_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lat_d     = lat_q;
    load      = 1'b0;
    unload_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
`ifdef HDU_PREFETCH_EN
    rd_done_d = rd_done_q;
`endif
    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
`ifdef HDU_PREFETCH_EN
        rd_done_d = 1'b0;
`endif
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        unload_en = 1'b1;
        busy      = 1'b1;
        lat_d     = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        busy  = 1'b1;
        lat_d = lat_q + 1'b1;
        if (lat_q == LAT_END) begin
          load    = 1'b1;
          state_d = ST_SEND;
`ifdef HDU_PREFETCH_EN
          if (final_addr) rd_done_d = 1'b1;
          else            addr_d    = addr_q + 1'b1;
`endif
        end
      end
      ST_SEND: begin
        busy = 1'b1;
        if (m_last && m_ready) begin
          state_d = ST_DONE;
`ifdef HDU_PREFETCH_EN
        end else if (!rd_done_q && can_load) begin
          state_d = ST_REQ;
`else
        end else if (addr_done) begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_REQ;
`endif
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign unloadAddress = addr_q;
  assign dbg_state     = state_q;

  ldpc_hd_beat_serializer #(
    .HDWIDTH(HDWIDTH),
    .Kb     (Kb)
  ) u_serializer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .final_i    (final_addr),
    .word_i     (unload_HDout_vec_regout),
    .ready_i    (m_ready),
    .data_o     (m_data),
    .valid_o    (m_valid),
    .last_o     (m_last),
`ifdef HDU_PREFETCH_EN
    .can_load_o (can_load)
`else
    .addr_done_o(addr_done)
`endif
  );

endmodule

// File: tb/tb_ldpc_hd_unloader.sv
// Self-checking bench for ldpc_hd_unloader: Lmem latency model, stream monitor, per-scenario tasks.
module tb_ldpc_hd_unloader;
  import ldpc_decoder_pkg::*;

  localparam int HDW    = 32;
  localparam int KB     = 14;
  localparam int DEPTH  = 16;
  localparam int AW     = 5;
  localparam int RDL    = 2;
  localparam int NBEATS = KB * DEPTH;
`ifdef HDU_PREFETCH_EN
  localparam int GAP = 0;
`else
  localparam int GAP = (DEPTH - 1) * (RDL + 1);
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              decoder_ready = 1'b0;
  logic              m_ready = 1'b0;
  logic [KB*HDW-1:0] hd_word;
  logic              unload_en;
  logic [AW-1:0]     unload_addr;
  logic [HDW-1:0]    m_data;
  logic              m_valid, m_last, busy, done;
  hdu_state_e        dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ldpc_hd_unloader #(
    .HDWIDTH(HDW), .Kb(KB), .UNLOAD_DEPTH(DEPTH), .ADDRESSWIDTH(AW), .RD_LATENCY(RDL)
  ) dut (
    .clk(clk), .rst(rst), .decoder_ready(decoder_ready),
    .unload_HDout_vec_regout(hd_word), .unload_en(unload_en), .unloadAddress(unload_addr),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Lmem model: word is valid exactly RDL cycles after the strobe, garbage otherwise.
  logic [HDW-1:0] lmem [DEPTH][KB];
  logic           p1_v, p2_v;
  logic [AW-1:0]  p1_a, p2_a;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_v <= 1'b0; p2_v <= 1'b0; p1_a <= '0; p2_a <= '0;
    end else begin
      p1_v <= unload_en; p1_a <= unload_addr;
      p2_v <= p1_v;      p2_a <= p1_a;
    end
  end

  always @* begin
    hd_word = {KB{32'hDEADBEEF}};
    if (p2_v)
      for (int c = 0; c < KB; c++) hd_word[c*HDW +: HDW] = lmem[p2_a[3:0]][c];
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: records accepted beats, strobes and pulses at the falling edge.
  logic [HDW-1:0] exp_q[$];
  logic [HDW-1:0] got_q[$];
  bit             last_q[$];
  logic [AW-1:0]  en_addr_q[$];
  int first_cyc, last_cyc, first_en_cyc, done_cyc, done_cnt;
  int stall_viol, en_double, stray_last;
  bit prev_stall, prev_en, prev_last;
  logic [HDW-1:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        last_q.push_back(m_last);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (m_last && !m_valid) stray_last++;
      if (prev_stall && !(m_valid && m_data == prev_data && m_last == prev_last)) stall_viol++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (unload_en) begin
        en_addr_q.push_back(unload_addr);
        if (first_en_cyc < 0) first_en_cyc = cyc;
        if (prev_en) en_double++;
      end
      prev_en = unload_en;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_mon();
    got_q.delete(); last_q.delete(); en_addr_q.delete();
    first_cyc = -1; last_cyc = -1; first_en_cyc = -1; done_cyc = -1; done_cnt = 0;
    stall_viol = 0; en_double = 0; stray_last = 0;
    prev_stall = 1'b0; prev_en = 1'b0; prev_last = 1'b0; prev_data = '0;
  endtask

  // Column c of address a is {a, c, low bits}; low bits zero or random per column.
  task automatic fill_lmem(input bit salted);
    exp_q.delete();
    for (int a = 0; a < DEPTH; a++) begin
      for (int c = 0; c < KB; c++) begin
        logic [4:0] a5;
        logic [3:0] c4;
        logic [22:0] lo;
        a5 = 5'(a);
        c4 = 4'(c);
        lo = salted ? 23'($urandom) : 23'h0;
        lmem[a][c] = {a5, c4, lo};
        exp_q.push_back({a5, c4, lo});
      end
    end
  endtask

  function automatic int count_bad_beats();
    int b = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) b++;
    return b;
  endfunction

  function automatic int count_bad_last();
    int b = 0;
    for (int i = 0; i < last_q.size(); i++)
      if (last_q[i] != (i == NBEATS - 1)) b++;
    return b;
  endfunction

  function automatic int count_bad_addr();
    int b = (en_addr_q.size() == DEPTH) ? 0 : 1;
    for (int i = 0; i < en_addr_q.size(); i++)
      if (en_addr_q[i] != AW'(i)) b++;
    return b;
  endfunction

  task automatic start_unload();
    @(posedge clk); #1 decoder_ready = 1'b0;
    @(posedge clk); #1 decoder_ready = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL %s_timeout: done not seen after %0d cycles, required within 3000", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    decoder_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (unload_en !== 1'b0) begin failures++; $display("FAIL reset_unload_en: got %b want 0", unload_en); end
    checks++; if (unload_addr !== '0) begin failures++; $display("FAIL reset_addr: got %0d want 0", unload_addr); end
    checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    fill_lmem(1'b0);
    ready_mode = 0;
    clear_mon();
    start_unload();
    wait_done("basic");
    checks++; if (got_q.size() != NBEATS) begin failures++; $display("FAIL basic_count: got %0d beats want %0d", got_q.size(), NBEATS); end
    checks++; if (count_bad_beats() != 0) begin failures++; $display("FAIL basic_data: %0d wrong beats want 0", count_bad_beats()); end
    checks++; if (count_bad_last() != 0 || stray_last != 0) begin failures++; $display("FAIL basic_last: %0d misplaced, %0d stray want 0", count_bad_last(), stray_last); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    checks++; if (done_cyc != last_cyc + 1) begin failures++; $display("FAIL basic_done_timing: done at %0d want %0d", done_cyc, last_cyc + 1); end
    checks++; if (count_bad_addr() != 0) begin failures++; $display("FAIL basic_addr_seq: %0d bad of %0d strobes want 16 ascending", count_bad_addr(), en_addr_q.size()); end
    checks++; if (en_double != 0) begin failures++; $display("FAIL basic_strobe_width: %0d multi-cycle strobes want 0", en_double); end
    checks++; if (first_cyc - first_en_cyc != RDL + 1) begin failures++; $display("FAIL basic_first_latency: got %0d want %0d", first_cyc - first_en_cyc, RDL + 1); end
    checks++; if (last_cyc - first_cyc != NBEATS - 1 + GAP) begin failures++; $display("FAIL basic_throughput: span %0d want %0d", last_cyc - first_cyc, NBEATS - 1 + GAP); end
    checks++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin failures++; $display("FAIL basic_idle_after: busy %b state %0d want 0/IDLE", busy, dbg_state); end
  endtask

  task automatic test_stall();
    fill_lmem(1'b1);
    ready_mode = 1;
    clear_mon();
    start_unload();
    wait_done("stall");
    checks++; if (got_q.size() != NBEATS) begin failures++; $display("FAIL stall_count: got %0d beats want %0d", got_q.size(), NBEATS); end
    checks++; if (count_bad_beats() != 0) begin failures++; $display("FAIL stall_data: %0d wrong beats want 0", count_bad_beats()); end
    checks++; if (stall_viol != 0) begin failures++; $display("FAIL stall_hold: %0d unstable stalls want 0", stall_viol); end
    checks++; if (count_bad_last() != 0) begin failures++; $display("FAIL stall_last: %0d misplaced want 0", count_bad_last()); end
  endtask

  task automatic test_random_ready();
    fill_lmem(1'b1);
    ready_mode = 2;
    clear_mon();
    start_unload();
    wait_done("rand");
    checks++; if (count_bad_beats() != 0) begin failures++; $display("FAIL rand_data: %0d wrong beats (got %0d) want 0", count_bad_beats(), got_q.size()); end
    checks++; if (stall_viol != 0) begin failures++; $display("FAIL rand_hold: %0d unstable stalls want 0", stall_viol); end
    checks++; if (count_bad_addr() != 0 || en_double != 0) begin failures++; $display("FAIL rand_strobes: %0d bad addr, %0d wide want 0/0", count_bad_addr(), en_double); end
  endtask

  task automatic test_restart_ignored();
    fill_lmem(1'b1);
    ready_mode = 2;
    clear_mon();
    start_unload();
    repeat (3) begin
      repeat ($urandom_range(20, 80)) @(posedge clk);
      #1 decoder_ready = 1'b0;
      @(posedge clk); #1 decoder_ready = 1'b1;
    end
    wait_done("restart");
    repeat (30) @(posedge clk);
    checks++; if (got_q.size() != NBEATS) begin failures++; $display("FAIL restart_count: got %0d beats want %0d", got_q.size(), NBEATS); end
    checks++; if (count_bad_beats() != 0) begin failures++; $display("FAIL restart_data: %0d wrong beats want 0", count_bad_beats()); end
    checks++; if (done_cnt != 1 || en_addr_q.size() != DEPTH) begin failures++; $display("FAIL restart_single: done %0d strobes %0d want 1/16", done_cnt, en_addr_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    fill_lmem(1'b1);
    ready_mode = 0;
    clear_mon();
    start_unload();
    while (got_q.size() < 100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (got_q.size() < 100) begin failures++; $display("FAIL midrst_reach: got %0d beats want 100", got_q.size()); end
    #2 rst = 1'b0;
    #1;
    checks++; if (unload_en !== 1'b0 || unload_addr !== '0) begin failures++; $display("FAIL midrst_lmem: en %b addr %0d want 0/0", unload_en, unload_addr); end
    checks++; if (m_data !== '0 || m_valid !== 1'b0 || m_last !== 1'b0) begin failures++; $display("FAIL midrst_stream: data %h valid %b last %b want 0", m_data, m_valid, m_last); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_status: busy %b done %b want 0/0", busy, done); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_mon();
    repeat (20) @(posedge clk);
    checks++; if (en_addr_q.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_no_start: strobes %0d busy %b want 0/0", en_addr_q.size(), busy); end
    start_unload();
    wait_done("midrst");
    checks++; if (count_bad_beats() != 0) begin failures++; $display("FAIL midrst_rerun: %0d wrong beats (got %0d) want 0", count_bad_beats(), got_q.size()); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_stall();
    test_random_ready();
    test_restart_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
